// File: rtl/bip_control_unit.sv
// BIP fetch/decode sequencer: runs a two-clock FETCH/EXEC cycle, produces the next PC
// (address_bus) with its load strobe (WrPC) and decodes each instruction into datapath controls.
// Optional feature: define BIP_CYCLE_COUNT_EN to add the cycle_count output.
module bip_control_unit #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       instr,
    output logic [ADDR_W-1:0] address_bus,
    output logic              WrPC,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              WrAcc,
    output logic              Op,
    output logic              WrRAM,
    output logic              RdRAM,
    output logic [ADDR_W-1:0] operand,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    localparam logic [OPC_W-1:0] OpcHlt  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OpcSto  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OpcLd   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OpcLdi  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OpcAdd  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OpcAddi = OPC_W'(5);
    localparam logic [OPC_W-1:0] OpcSub  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OpcSubi = OPC_W'(7);

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic [OPC_W-1:0]   opcode;
    logic               dec_illegal;
    logic               dec_halt;

    assign opcode      = instr[15:16-OPC_W];
    assign operand     = instr[ADDR_W-1:0];
    // Next sequential address; wraps silently at the top of program memory.
    assign address_bus = Addr + ADDR_W'(1);
    assign halted      = (state_q == StHalt);
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;
    assign dec_halt    = (opcode == OpcHlt);

    // State register and status counters, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic for the sequencer and the status counters.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: state_d = StExec;
            StExec: begin
                state_d = dec_halt ? StHalt : StFetch;
                if (dec_illegal) illegal_d = 1'b1;
                // Saturate rather than wrap so a long run never looks short.
                if (!dec_halt && (instr_count_q != {CNT_W{1'b1}})) begin
                    instr_count_d = instr_count_q + CNT_W'(1);
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Decode: strobes are purely combinational from (state, instr) and only live in EXEC.
    always_comb begin
        WrPC        = 1'b0;
        SelA        = 2'b00;
        SelB        = 1'b0;
        WrAcc       = 1'b0;
        Op          = 1'b0;
        WrRAM       = 1'b0;
        RdRAM       = 1'b0;
        dec_illegal = 1'b0;
        if (state_q == StExec) begin
            WrPC = !dec_halt;
            case (opcode)
                OpcHlt: ;
                OpcSto: WrRAM = 1'b1;
                OpcLd: begin
                    RdRAM = 1'b1;
                    WrAcc = 1'b1;
                end
                OpcLdi: begin
                    SelA  = 2'b01;
                    WrAcc = 1'b1;
                end
                OpcAdd: begin
                    RdRAM = 1'b1;
                    SelA  = 2'b10;
                    WrAcc = 1'b1;
                end
                OpcAddi: begin
                    SelB  = 1'b1;
                    SelA  = 2'b10;
                    WrAcc = 1'b1;
                end
                OpcSub: begin
                    RdRAM = 1'b1;
                    Op    = 1'b1;
                    SelA  = 2'b10;
                    WrAcc = 1'b1;
                end
                OpcSubi: begin
                    SelB  = 1'b1;
                    Op    = 1'b1;
                    SelA  = 2'b10;
                    WrAcc = 1'b1;
                end
                // Unknown opcodes execute as NOP but are remembered.
                default: dec_illegal = 1'b1;
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    assign cycle_count = cycle_count_q;

    // Next value of the active-cycle counter: runs only while fetching or executing.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if ((state_q == StFetch) || (state_q == StExec)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Active-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_count_q <= '0;
        else        cycle_count_q <= cycle_count_d;
    end
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: table-driven instruction vectors with a
// scoreboard queue, plus hand-written HLT, illegal-opcode and mid-instruction reset sequences.
module tb_bip_control_unit;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] Addr;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] address_bus;
    logic              WrPC;
    logic [1:0]        SelA;
    logic              SelB;
    logic              WrAcc;
    logic              Op;
    logic              WrRAM;
    logic              RdRAM;
    logic [ADDR_W-1:0] operand;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  instr_count;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0]       cycle_count;
`endif

    bip_control_unit #(
        .ADDR_W(ADDR_W),
        .OPC_W (5),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .Addr       (Addr),
        .instr      (instr),
        .address_bus(address_bus),
        .WrPC       (WrPC),
        .SelA       (SelA),
        .SelB       (SelB),
        .WrAcc      (WrAcc),
        .Op         (Op),
        .WrRAM      (WrRAM),
        .RdRAM      (RdRAM),
        .operand    (operand),
        .halted     (halted),
        .illegal    (illegal),
        .instr_count(instr_count)
`ifdef BIP_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle: {SelA[1:0], SelB, WrAcc, Op, WrRAM, RdRAM, WrPC}
    logic [7:0] ctrl_act;
    assign ctrl_act = {SelA, SelB, WrAcc, Op, WrRAM, RdRAM, WrPC};

    typedef struct {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        ctrl;
        logic [ADDR_W-1:0] bus;
        logic [ADDR_W-1:0] opnd;
        logic              ill;
    } vec_t;

    typedef struct {
        logic [7:0]        ctrl;
        logic [ADDR_W-1:0] bus;
        logic [ADDR_W-1:0] opnd;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one FETCH/EXEC pair without checking; entered and left at a FETCH negedge.
    task automatic run_instr(input logic [15:0] i, input logic [ADDR_W-1:0] a);
        instr = i;
        Addr  = a;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   exp_cnt;
        logic seen_ill;

        vecs[0] = '{16'h1803, 11'd5,    8'b01010001, 11'd6,    11'h003, 1'b0}; // LDI 3
        vecs[1] = '{16'h2007, 11'd6,    8'b10010011, 11'd7,    11'h007, 1'b0}; // ADD 7
        vecs[2] = '{16'h3801, 11'd2047, 8'b10111001, 11'd0,    11'h001, 1'b0}; // SUBI 1, wrap
        vecs[3] = '{16'h0812, 11'd100,  8'b00000101, 11'd101,  11'h012, 1'b0}; // STO
        vecs[4] = '{16'h1005, 11'd200,  8'b00010011, 11'd201,  11'h005, 1'b0}; // LD
        vecs[5] = '{16'h2805, 11'd300,  8'b10110001, 11'd301,  11'h005, 1'b0}; // ADDI
        vecs[6] = '{16'h3009, 11'd400,  8'b10011011, 11'd401,  11'h009, 1'b0}; // SUB
        vecs[7] = '{16'hF8AB, 11'd500,  8'b00000001, 11'd501,  11'h0AB, 1'b1}; // opcode 11111
        vecs[8] = '{16'h1C00, 11'd1023, 8'b01010001, 11'd1024, 11'h400, 1'b0}; // LDI after illegal

        rst_n = 1'b0;
        start = 1'b0;
        Addr  = '0;
        instr = 16'h1803;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'(ctrl_act), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_count", 32'(instr_count), 32'h0);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_ctrl", 32'(ctrl_act), 32'h0);
        check("idle_count", 32'(instr_count), 32'h0);
        check("idle_illegal", 32'(illegal), 32'h0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        exp_cnt  = 0;
        seen_ill = 1'b0;
        for (int i = 0; i < 9; i++) begin
            Addr  = vecs[i].addr;
            instr = vecs[i].instr;
            sb.push_back('{vecs[i].ctrl, vecs[i].bus, vecs[i].opnd});
            #1;
            check($sformatf("fetch_ctrl[%0d]", i), 32'(ctrl_act), 32'h0);
            @(negedge clk);
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'(sb.size()), 32'h1);
            end else begin
                e = sb.pop_front();
                check($sformatf("exec_ctrl[%0d]", i), 32'(ctrl_act), 32'(e.ctrl));
                check($sformatf("exec_bus[%0d]", i), 32'(address_bus), 32'(e.bus));
                check($sformatf("exec_operand[%0d]", i), 32'(operand), 32'(e.opnd));
            end
            exp_cnt++;
            seen_ill = seen_ill | vecs[i].ill;
            @(negedge clk);
            check($sformatf("count[%0d]", i), 32'(instr_count), 32'(exp_cnt));
            check($sformatf("illegal[%0d]", i), 32'(illegal), 32'(seen_ill));
            check($sformatf("halted[%0d]", i), 32'(halted), 32'h0);
        end

        // HLT: no strobes in EXEC, then parked in HALT regardless of start.
        instr = 16'h0000;
        Addr  = 11'd600;
        @(negedge clk);
        check("hlt_exec_ctrl", 32'(ctrl_act), 32'h0);
        @(negedge clk);
        instr = 16'h1803;
        #1;
        check("hlt_halted", 32'(halted), 32'h1);
        check("hlt_ctrl", 32'(ctrl_act), 32'h0);
        check("hlt_count", 32'(instr_count), 32'(exp_cnt));
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check($sformatf("halt_hold[%0d]", k), 32'({halted, WrPC}), 32'h2);
        end
        check("halt_count_hold", 32'(instr_count), 32'(exp_cnt));
        check("halt_illegal_hold", 32'(illegal), 32'h1);

`ifdef BIP_CYCLE_COUNT_EN
        rst_n = 1'b0;
        @(negedge clk);
        check("cyc_reset", cycle_count, 32'd0);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_instr(16'h1801, 11'd10);
        run_instr(16'h2802, 11'd11);
        run_instr(16'h0000, 11'd12);
        check("cyc_after_hlt", cycle_count, 32'd6);
        repeat (4) @(negedge clk);
        check("cyc_frozen", cycle_count, 32'd6);
`endif

        // Reset in the middle of an STO execute must kill WrRAM immediately.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_instr(16'h1801, 11'd20);
        instr = 16'h0812;
        Addr  = 11'd21;
        @(negedge clk);
        check("sto_wrram", 32'(WrRAM), 32'h1);
        check("sto_count_before", 32'(instr_count), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 32'(ctrl_act), 32'h0);
        check("midreset_count", 32'(instr_count), 32'h0);
        check("midreset_illegal", 32'(illegal), 32'h0);
        check("midreset_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_idle", 32'(ctrl_act), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
